// File: rtl/seg7_multi_driver.sv
`default_nettype none
// ============================================================================
// seg7_multi_driver
//   Registered N-digit hex to active-low 7-segment driver with leading-zero
//   blanking, per-digit blink and decimal point, and PWM brightness.
//   Revision: 1.0
// ============================================================================
module seg7_multi_driver #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter int PWM_BITS   = 4
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic                    iLOAD,
  input  logic [4*NUM_DIGITS-1:0] iVALUE,
  input  logic [NUM_DIGITS-1:0]   iDP,
  input  logic [NUM_DIGITS-1:0]   iBLINK_EN,
  input  logic                    iBLANK_LZ,
  input  logic [PWM_BITS-1:0]     iBRIGHT,
  output logic [7*NUM_DIGITS-1:0] oSEG,
  output logic [NUM_DIGITS-1:0]   oDP,
  output logic                    oBLINK_PH
);

  localparam int              BCW          = $clog2(BLINK_DIV);
  localparam logic [BCW-1:0]  C_BLINK_LAST = BCW'(BLINK_DIV - 1);
  localparam logic [6:0]      C_SEG_BLANK  = 7'h7F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h18;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  logic [4*NUM_DIGITS-1:0] value_q,    value_d;
  logic [NUM_DIGITS-1:0]   dp_q,       dp_d;
  logic [NUM_DIGITS-1:0]   blink_en_q, blink_en_d;
  logic [BCW-1:0]          blink_cnt_q, blink_cnt_d;
  logic                    blink_ph_q, blink_ph_d;
  logic [PWM_BITS-1:0]     pwm_cnt_q,  pwm_cnt_d;
  logic [7*NUM_DIGITS-1:0] seg_q,      seg_d;
  logic [NUM_DIGITS-1:0]   dpo_q,      dpo_d;

  logic                    blink_wrap;
  logic                    pwm_lit;

  always_comb begin
    value_d    = iLOAD ? iVALUE    : value_q;
    dp_d       = iLOAD ? iDP       : dp_q;
    blink_en_d = iLOAD ? iBLINK_EN : blink_en_q;

    blink_wrap  = (blink_cnt_q == C_BLINK_LAST);
    blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + BCW'(1);
    blink_ph_d  = blink_ph_q ^ blink_wrap;

    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    pwm_lit   = (&iBRIGHT) || (pwm_cnt_q < iBRIGHT);
  end

  // Per-digit output path: decode, then LZ, blink and PWM masks in turn.
  always_comb begin : p_digits
    logic       lead;
    logic [3:0] nib;
    logic [6:0] seg_k;
    logic       dp_k;
    logic       dark;

    seg_d = '1;
    dpo_d = '1;
    lead  = iBLANK_LZ;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nib   = value_q[4*k +: 4];
      seg_k = hex_to_seg(nib);
      dp_k  = dp_q[k];
      dark  = 1'b0;

      if (lead && (nib == 4'h0) && !dp_q[k] && (k != 0)) begin
        dark = 1'b1;
      end
      if ((nib != 4'h0) || dp_q[k]) begin
        lead = 1'b0;
      end

      if (blink_ph_q && blink_en_q[k]) begin
        dark = 1'b1;
      end
      if (!pwm_lit) begin
        dark = 1'b1;
      end

      if (dark) begin
        seg_k = C_SEG_BLANK;
        dp_k  = 1'b0;
      end

      seg_d[7*k +: 7] = seg_k;
      dpo_d[k]        = ~dp_k;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      value_q     <= '0;
      dp_q        <= '0;
      blink_en_q  <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      pwm_cnt_q   <= '0;
      seg_q       <= '1;
      dpo_q       <= '1;
    end else begin
      value_q     <= value_d;
      dp_q        <= dp_d;
      blink_en_q  <= blink_en_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      pwm_cnt_q   <= pwm_cnt_d;
      seg_q       <= seg_d;
      dpo_q       <= dpo_d;
    end
  end

  assign oSEG      = seg_q;
  assign oDP       = dpo_q;
  assign oBLINK_PH = blink_ph_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_multi_driver.sv
`default_nettype none
// ============================================================================
// tb_seg7_multi_driver
//   Scoreboard bench: driver pushes predicted outputs, monitor pops and checks.
//   Revision: 1.0
// ============================================================================
module tb_seg7_multi_driver;

  localparam int ND  = 6;
  localparam int BDV = 4;
  localparam int PB  = 2;

  logic          clk;
  logic          rst_n;
  logic          load;
  logic [4*ND-1:0] value;
  logic [ND-1:0] dp;
  logic [ND-1:0] blink_en;
  logic          blank_lz;
  logic [PB-1:0] bright;
  logic [7*ND-1:0] seg;
  logic [ND-1:0] dpo;
  logic          blink_ph;

  seg7_multi_driver #(
    .NUM_DIGITS (ND),
    .BLINK_DIV  (BDV),
    .PWM_BITS   (PB)
  ) dut (
    .iCLK      (clk),
    .iRST_N    (rst_n),
    .iLOAD     (load),
    .iVALUE    (value),
    .iDP       (dp),
    .iBLINK_EN (blink_en),
    .iBLANK_LZ (blank_lz),
    .iBRIGHT   (bright),
    .oSEG      (seg),
    .oDP       (dpo),
    .oBLINK_PH (blink_ph)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7*ND-1:0] seg;
    logic [ND-1:0]   dp;
    logic            ph;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: captured state plus edges elapsed since the last reset.
  logic [4*ND-1:0] m_value;
  logic [ND-1:0]   m_dp;
  logic [ND-1:0]   m_ben;
  int              m_n;

  task automatic drive(input logic r, input logic ld, input logic [4*ND-1:0] v,
                       input logic [ND-1:0] d, input logic [ND-1:0] be,
                       input logic lz, input logic [PB-1:0] br);
    exp_t e;
    int   top;
    int   p;
    logic phase;
    logic blank;
    @(negedge clk);
    rst_n = r; load = ld; value = v; dp = d; blink_en = be; blank_lz = lz; bright = br;
    if (!r) begin
      e.seg = '1; e.dp = '1; e.ph = 1'b0;
      m_value = '0; m_dp = '0; m_ben = '0; m_n = 0;
    end else begin
      phase = ((m_n / BDV) % 2) == 1;
      p     = m_n % (1 << PB);
      top   = 0;
      for (int k = 0; k < ND; k++)
        if (m_value[4*k +: 4] != 4'h0 || m_dp[k]) top = k;
      for (int k = 0; k < ND; k++) begin
        blank = (lz && k > top) || (phase && m_ben[k]) ||
                !(int'(br) == (1 << PB) - 1 || p < int'(br));
        e.seg[7*k +: 7] = blank ? 7'h7F : seg_tab[m_value[4*k +: 4]];
        e.dp[k]         = ~(!blank && m_dp[k]);
      end
      e.ph = (((m_n + 1) / BDV) % 2) == 1;
      if (ld) begin
        m_value = v; m_dp = d; m_ben = be;
      end
      m_n++;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic lz, input logic [PB-1:0] br);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, '0, '0, '0, lz, br);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (seg !== e.seg) begin
          errors++;
          $display("FAIL seg @%0t: got %h expected %h", $time, seg, e.seg);
        end
        checks++;
        if (dpo !== e.dp) begin
          errors++;
          $display("FAIL dp @%0t: got %h expected %h", $time, dpo, e.dp);
        end
        checks++;
        if (blink_ph !== e.ph) begin
          errors++;
          $display("FAIL blink_ph @%0t: got %b expected %b", $time, blink_ph, e.ph);
        end
      end
    end
  end

  initial begin : stimulus
    int guard;
    rst_n = 1'b0; load = 1'b0; value = '0; dp = '0; blink_en = '0;
    blank_lz = 1'b0; bright = 2'd3;
    m_value = '0; m_dp = '0; m_ben = '0; m_n = 0;

    // Reset for 3 clocks
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 2'd3);

    // Decode and latency
    drive(1'b1, 1'b1, 24'h01234F, '0, '0, 1'b0, 2'd3);
    idle(3, 1'b0, 2'd3);

    // Leading-zero blanking
    drive(1'b1, 1'b1, 24'h000120, '0, '0, 1'b1, 2'd3);
    idle(2, 1'b1, 2'd3);
    drive(1'b1, 1'b1, 24'h000000, '0, '0, 1'b1, 2'd3);
    idle(2, 1'b1, 2'd3);
    drive(1'b1, 1'b1, 24'h000120, 6'b001000, '0, 1'b1, 2'd3);
    idle(2, 1'b1, 2'd3);

    // Blink on digit 0
    drive(1'b1, 1'b1, 24'h111111, '0, 6'b000001, 1'b0, 2'd3);
    idle(16, 1'b0, 2'd3);

    // PWM brightness sweep
    idle(12, 1'b0, 2'd1);
    idle(8, 1'b0, 2'd0);
    idle(8, 1'b0, 2'd2);
    idle(4, 1'b0, 2'd3);

    // Reset during the blink-dark phase, then reload
    guard = 0;
    while (((m_n / BDV) % 2) != 1 && guard < 2 * BDV) begin
      idle(1, 1'b0, 2'd3);
      guard++;
    end
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 2'd3);
    drive(1'b1, 1'b1, 24'hABCDEF, 6'b100001, 6'b000001, 1'b0, 2'd3);
    idle(4, 1'b0, 2'd3);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic [4*ND-1:0] v;
      v = 24'($urandom()) >> (4 * $urandom_range(0, ND));
      drive(($urandom_range(0, 39) != 0), 1'($urandom()), v,
            6'($urandom()) & 6'($urandom()), 6'($urandom()),
            1'($urandom()), 2'($urandom()));
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected outputs never checked, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
